usb_rx_nrzi_unstuff: RTL and testbench
======================================

# usb_rx_nrzi_unstuff

Parametrised receive-side line decoder for the USB full-speed RX path. It sits between the bit-timing generator and the RX shift register.
- Synchronises the raw differential pair.
- Performs NRZI decoding on each `shift_enable` sample point.
- Removes stuffed bits and flags stuffing violations.
- Detects SE0-based end-of-packet.

It emits one decoded data bit per qualified sample, with a valid strobe, so the shift register only shifts on real payload bits.

## Interface
Parameters:
- `STUFF_LEN`, default 6: consecutive decoded 1s after which the next bit is a stuff bit. Legal range 2–15.
- `SYNC_STAGES`, default 2: flip-flop stages per input synchroniser. Legal range 2–4.
- `EOP_SE0_BITS`, default 2: consecutive SE0 samples that constitute EOP. Legal range 1–3.

Ports:
- `clk` input 1: system clock; all state updates on its rising edge.
- `n_rst` input 1: reset, synchronous, active-low.
- `d_plus` input 1: raw D+ line, asynchronous.
- `d_minus` input 1: raw D− line, asynchronous.
- `shift_enable` input 1: one-cycle sample strobe from the bit timer; may be high on consecutive cycles.
- `d_orig` output 1: last decoded payload bit (held).
- `bit_valid` output 1: one-cycle pulse, `d_orig` updated with a new payload bit.
- `stuff_err` output 1: one-cycle pulse, stuff bit was a 1 (violation).
- `eop` output 1: one-cycle pulse, EOP detected.
- `se0` output 1: level, synchronised line currently SE0.

## Operation
- Each synchroniser chain resets to the idle J state: D+ chain = 1, D− chain = 0. Synchronised values are `dp_s` and `dm_s`.
- Line state from the synchronised pair:
  - J = (1,0)
  - K = (0,1)
  - SE0 = (0,0)
  - (1,1) is treated as J.
- Internal registers:
  - `prev_lvl` resets to 1.
  - `ones_cnt`, width clog2(STUFF_LEN+1), resets to 0.
  - `se0_cnt` resets to 0.
  - `state` resets to DATA.
- Nothing changes on cycles where `shift_enable` = 0, except `se0`, which tracks the line every cycle.
- On a `shift_enable` cycle whose sample is not SE0:
  - Raw decoded bit `b = (dp_s == prev_lvl)`.
  - Then `prev_lvl <= dp_s` and `se0_cnt <= 0`.
- State DATA:
  - If `b` = 1: `d_orig <= 1`, pulse `bit_valid`, `ones_cnt++`. If the incremented count equals STUFF_LEN, go to STUFF.
  - If `b` = 0: `d_orig <= 0`, pulse `bit_valid`, `ones_cnt <= 0`.
- State STUFF:
  - The bit is discarded: no `bit_valid`, `d_orig` holds.
  - If `b` = 1, pulse `stuff_err`.
  - In both cases `ones_cnt <= 0` and go to DATA.
- SE0 sample (any state):
  - No `bit_valid`, no `stuff_err`, `ones_cnt <= 0`, `se0_cnt++`.
  - `se0_cnt` saturates at EOP_SE0_BITS.
  - Go to SE0_WAIT.
  - When `se0_cnt` reaches EOP_SE0_BITS, pulse `eop` once.
- State SE0_WAIT:
  - A following J or K sample does not produce a decoded bit.
  - `prev_lvl <= 1` (NRZI reference restored to J), go to DATA.
- `eop` pulses at most once per SE0 run. Further SE0 samples keep `se0_cnt` saturated with no repeat pulse.

## Timing
- Reset values:
  - `d_orig` = 1.
  - `bit_valid`, `stuff_err`, `eop`, `se0` = 0.
  - Synchronisers at J.
- Input latency: a level change on `d_plus`/`d_minus` at edge t is in `dp_s`/`dm_s` after edge t+SYNC_STAGES. A sample taken on that cycle or later sees it.
- Output latency: all outputs are registered. A sample on cycle n produces `d_orig`/`bit_valid`/`stuff_err`/`eop` visible during cycle n+1.
- `se0` lags the synchroniser output by 1 cycle.
- Each pulse is exactly one cycle wide, including when `shift_enable` is high on back-to-back cycles.
- SE0 during STUFF: SE0 wins. No `stuff_err`, counter cleared.
- `ones_cnt` never exceeds STUFF_LEN. A violation clears it rather than wrapping.
- `n_rst` low at any edge, including mid-packet or during SE0: all registers return to reset values at that edge. A `shift_enable` on that cycle is ignored.

## Structure
- Shared package `usb_rx_pkg`:
  - State enum `rx_dec_state_t` {DATA, STUFF, SE0_WAIT}.
  - Line constants LINE_J/LINE_K/LINE_SE0 (2-bit {dp,dm}).
  - Default STUFF_LEN.
- Sub-module `sync_chain` (parameters STAGES and RST_VAL, 1-bit). Instantiated twice: D+ with RST_VAL = 1, D− with RST_VAL = 0.

## Test plan
- Reset then idle J; strobe 3 samples → `d_orig` = 1 on each; `bit_valid` pulses 3×, one cycle after each strobe; `stuff_err` = `eop` = 0.
- Line sequence J,K,K,J,J,K (one strobe each, levels held ≥ SYNC_STAGES+1 cycles) → decoded bits 1,0,1,0,1,0.
- STUFF_LEN = 6: K followed by six K samples, then J → bits 0,1,1,1,1,1,1; the J sample produces no `bit_valid`; next sample J → bit 1.
- Same as above but seventh sample K instead of J → `stuff_err` pulses once, no `bit_valid` for that sample, `ones_cnt` = 0 afterwards.
- EOP_SE0_BITS = 2: data, then SE0, SE0, J → `eop` pulses once, one cycle after the second SE0 strobe; the J sample yields no bit; the next K yields 0.
- `n_rst` pulsed low mid-packet with `ones_cnt` = 4 and a strobe on the same cycle → all outputs at reset values the next cycle; the next J sample decodes 1.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
package usb_rx_pkg;

   typedef enum logic [1:0] {
      DATA,
      STUFF,
      SE0_WAIT
   } rx_dec_state_t;

   // Line states packed as {dp, dm}
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   localparam int DEFAULT_STUFF_LEN = 6;

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchroniser with a selectable reset level.
module sync_chain #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic n_rst,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] stage_reg;
   logic [STAGES-1:0] stage_next;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign stage_next[gi] = din;
         end else begin : g_rest
            assign stage_next[gi] = stage_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         stage_reg <= {STAGES{RST_VAL}};
      end else begin
         stage_reg <= stage_next;
      end
   end

   assign dout = stage_reg[STAGES-1];

endmodule

// File: rtl/usb_rx_nrzi_unstuff.sv
// USB full-speed RX line decoder: input synchronisation, NRZI decode,
// bit unstuffing with violation flag, and SE0-based end-of-packet detection.
module usb_rx_nrzi_unstuff
   import usb_rx_pkg::*;
#(
   parameter int STUFF_LEN    = DEFAULT_STUFF_LEN,
   parameter int SYNC_STAGES  = 2,
   parameter int EOP_SE0_BITS = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic d_plus,
   input  logic d_minus,
   input  logic shift_enable,
   output logic d_orig,
   output logic bit_valid,
   output logic stuff_err,
   output logic eop,
   output logic se0
);

   localparam int OW = $clog2(STUFF_LEN + 1);
   localparam int SW = $clog2(EOP_SE0_BITS + 1);
   localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
   localparam logic [SW-1:0] SE0_MAX  = SW'(EOP_SE0_BITS);

   logic [1:0] line_raw;
   logic [1:0] line_s;
   logic       dp_s;
   logic       dm_s;

   assign line_raw = {d_plus, d_minus};

   // Bit 1 carries D+ and bit 0 carries D-, so the J constant gives each chain its idle level
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         sync_chain #(
            .STAGES  (SYNC_STAGES),
            .RST_VAL (LINE_J[gi])
         ) u_sync (
            .clk   (clk),
            .n_rst (n_rst),
            .din   (line_raw[gi]),
            .dout  (line_s[gi])
         );
      end
   endgenerate

   assign dp_s = line_s[1];
   assign dm_s = line_s[0];

   rx_dec_state_t state_reg;
   logic          prev_lvl_reg;
   logic [OW-1:0] ones_cnt_reg;
   logic [OW-1:0] ones_cnt_next;
   logic [SW-1:0] se0_cnt_reg;
   logic [SW-1:0] se0_cnt_next;
   logic          d_orig_reg;
   logic          bit_valid_reg;
   logic          stuff_err_reg;
   logic          eop_reg;
   logic          se0_reg;
   logic          line_se0;
   logic          raw_bit;

   assign line_se0      = ({dp_s, dm_s} == LINE_SE0);
   assign raw_bit       = (dp_s == prev_lvl_reg);
   assign ones_cnt_next = ones_cnt_reg + OW'(1);
   assign se0_cnt_next  = se0_cnt_reg + SW'(1);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_reg     <= DATA;
         prev_lvl_reg  <= 1'b1;
         ones_cnt_reg  <= '0;
         se0_cnt_reg   <= '0;
         d_orig_reg    <= 1'b1;
         bit_valid_reg <= 1'b0;
         stuff_err_reg <= 1'b0;
         eop_reg       <= 1'b0;
         se0_reg       <= 1'b0;
      end else begin
         bit_valid_reg <= 1'b0;
         stuff_err_reg <= 1'b0;
         eop_reg       <= 1'b0;
         se0_reg       <= line_se0;
         if (shift_enable) begin
            if (line_se0) begin
               // SE0 overrides any pending stuff bit; saturating counter gives one eop per run
               ones_cnt_reg <= '0;
               state_reg    <= SE0_WAIT;
               if (se0_cnt_reg != SE0_MAX) begin
                  se0_cnt_reg <= se0_cnt_next;
                  if (se0_cnt_next == SE0_MAX) begin
                     eop_reg <= 1'b1;
                  end
               end
            end else begin
               prev_lvl_reg <= dp_s;
               se0_cnt_reg  <= '0;
               case (state_reg)
                  DATA: begin
                     d_orig_reg    <= raw_bit;
                     bit_valid_reg <= 1'b1;
                     if (raw_bit) begin
                        ones_cnt_reg <= ones_cnt_next;
                        if (ones_cnt_next == ONES_MAX) begin
                           state_reg <= STUFF;
                        end
                     end else begin
                        ones_cnt_reg <= '0;
                     end
                  end
                  STUFF: begin
                     stuff_err_reg <= raw_bit;
                     ones_cnt_reg  <= '0;
                     state_reg     <= DATA;
                  end
                  default: begin
                     // First symbol after SE0 is not decoded; reference level returns to J
                     prev_lvl_reg <= 1'b1;
                     ones_cnt_reg <= '0;
                     state_reg    <= DATA;
                  end
               endcase
            end
         end
      end
   end

   assign d_orig    = d_orig_reg;
   assign bit_valid = bit_valid_reg;
   assign stuff_err = stuff_err_reg;
   assign eop       = eop_reg;
   assign se0       = se0_reg;

endmodule

// File: tb/tb_usb_rx_nrzi_unstuff.sv
// Randomised and directed bench for usb_rx_nrzi_unstuff against a
// sample-level behavioural model of the USB RX decode rules.
module tb_usb_rx_nrzi_unstuff;

   localparam int STUFF_LEN    = 6;
   localparam int SYNC_STAGES  = 2;
   localparam int EOP_SE0_BITS = 2;

   localparam logic [1:0] J   = 2'b10;
   localparam logic [1:0] K   = 2'b01;
   localparam logic [1:0] SE0 = 2'b00;
   localparam logic [1:0] JJ  = 2'b11;

   logic tb_clk = 1'b0;
   logic n_rst;
   logic d_plus;
   logic d_minus;
   logic shift_enable;
   logic d_orig;
   logic bit_valid;
   logic stuff_err;
   logic eop;
   logic se0;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic m_ref;
   int   m_run;
   bit   m_expect_stuff;
   int   m_se0_run;
   bit   m_skip_next;
   logic m_d;
   logic e_valid;
   logic e_serr;
   logic e_eop;

   always #5 tb_clk = ~tb_clk;

   usb_rx_nrzi_unstuff #(
      .STUFF_LEN    (STUFF_LEN),
      .SYNC_STAGES  (SYNC_STAGES),
      .EOP_SE0_BITS (EOP_SE0_BITS)
   ) dut (
      .clk          (tb_clk),
      .n_rst        (n_rst),
      .d_plus       (d_plus),
      .d_minus      (d_minus),
      .shift_enable (shift_enable),
      .d_orig       (d_orig),
      .bit_valid    (bit_valid),
      .stuff_err    (stuff_err),
      .eop          (eop),
      .se0          (se0)
   );

   task automatic model_reset();
      m_ref          = 1'b1;
      m_run          = 0;
      m_expect_stuff = 0;
      m_se0_run      = 0;
      m_skip_next    = 0;
      m_d            = 1'b1;
      e_valid        = 1'b0;
      e_serr         = 1'b0;
      e_eop          = 1'b0;
   endtask

   // One qualified sample: NRZI bit is 1 when the level did not change
   task automatic model_step(input logic [1:0] line);
      logic lvl;
      logic b;
      e_valid = 1'b0;
      e_serr  = 1'b0;
      e_eop   = 1'b0;
      if (line == SE0) begin
         m_run          = 0;
         m_expect_stuff = 0;
         m_skip_next    = 1;
         m_se0_run      = m_se0_run + 1;
         e_eop          = (m_se0_run == EOP_SE0_BITS);
      end else begin
         lvl       = line[1];
         b         = (lvl == m_ref);
         m_se0_run = 0;
         if (m_skip_next) begin
            m_skip_next = 0;
            m_ref       = 1'b1;
            m_run       = 0;
         end else if (m_expect_stuff) begin
            m_expect_stuff = 0;
            e_serr         = b;
            m_run          = 0;
            m_ref          = lvl;
         end else begin
            e_valid = 1'b1;
            m_d     = b;
            m_run   = b ? m_run + 1 : 0;
            if (m_run == STUFF_LEN) m_expect_stuff = 1;
            m_ref = lvl;
         end
      end
   endtask

   // Hold a line state long enough to pass the synchroniser, then strobe n times back to back
   task automatic apply(input string name, input logic [1:0] line, input int n);
      logic [4:0] obs;
      logic [4:0] exp;
      d_plus  = line[1];
      d_minus = line[0];
      repeat (SYNC_STAGES + 1) @(posedge tb_clk);
      #1;
      shift_enable = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge tb_clk);
         #1;
         model_step(line);
         obs = {d_orig, bit_valid, stuff_err, eop, se0};
         exp = {m_d, e_valid, e_serr, e_eop, (line == SE0)};
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL %s strobe %0d: d_orig/valid/stuff_err/eop/se0 got %b want %b", name, i, obs, exp);
         end
      end
      shift_enable = 1'b0;
      @(posedge tb_clk);
      #1;
      obs = {d_orig, bit_valid, stuff_err, eop, se0};
      exp = {m_d, 1'b0, 1'b0, 1'b0, (line == SE0)};
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s idle after strobes: got %b want %b", name, obs, exp);
      end
      $display("%s: line=%b strobes=%0d d_orig=%b", name, line, n, d_orig);
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      n_rst        = 1'b0;
      shift_enable = 1'b0;
      d_plus       = 1'b1;
      d_minus      = 1'b0;
      repeat (SYNC_STAGES + 1) @(posedge tb_clk);
      #1;
      obs = {d_orig, bit_valid, stuff_err, eop, se0};
      n_vec++;
      if (obs !== 5'b10000) begin
         n_err++;
         $display("FAIL reset values: got %b want %b", obs, 5'b10000);
      end
      n_rst = 1'b1;
      model_reset();
      $display("reset: outputs=%b", obs);
   endtask

   task automatic test_idle_j();
      test_reset();
      apply("idle_j", J, 3);
   endtask

   task automatic test_nrzi();
      logic [1:0] seq [6];
      seq = '{J, K, K, J, J, K};
      test_reset();
      for (int i = 0; i < 6; i++) apply("nrzi", seq[i], 1);
      apply("nrzi_jj_as_j", JJ, 1);
   endtask

   task automatic test_stuff_ok();
      test_reset();
      apply("stuff_ok", K, 1);
      apply("stuff_ok", K, 6);
      apply("stuff_ok_bit", J, 1);
      apply("stuff_ok_after", J, 1);
   endtask

   task automatic test_stuff_err();
      test_reset();
      apply("stuff_err", K, 1);
      apply("stuff_err", K, 7);
      apply("stuff_err_after", K, 1);
   endtask

   task automatic test_eop();
      test_reset();
      apply("eop_data", J, 2);
      apply("eop_data", K, 1);
      apply("eop_se0", SE0, 2);
      apply("eop_first_j", J, 1);
      apply("eop_next_k", K, 1);
      apply("eop_long_se0", SE0, 4);
      apply("eop_long_j", J, 2);
   endtask

   task automatic test_se0_in_stuff();
      test_reset();
      apply("se0_stuff", K, 1);
      apply("se0_stuff", K, 6);
      apply("se0_stuff_se0", SE0, 1);
      apply("se0_stuff_j", J, 1);
      apply("se0_stuff_k", K, 3);
   endtask

   task automatic test_reset_mid();
      logic [4:0] obs;
      test_reset();
      apply("mid_rst_ones", J, 4);
      d_plus  = 1'b0;
      d_minus = 1'b1;
      repeat (SYNC_STAGES + 1) @(posedge tb_clk);
      #1;
      n_rst        = 1'b0;
      shift_enable = 1'b1;
      @(posedge tb_clk);
      #1;
      shift_enable = 1'b0;
      n_rst        = 1'b1;
      model_reset();
      obs = {d_orig, bit_valid, stuff_err, eop, se0};
      n_vec++;
      if (obs !== 5'b10000) begin
         n_err++;
         $display("FAIL mid-packet reset: got %b want %b", obs, 5'b10000);
      end
      $display("mid_rst: outputs=%b", obs);
      apply("mid_rst_j", J, 1);
      apply("mid_rst_run", J, 6);
   endtask

   task automatic test_random();
      logic [1:0] line;
      int r;
      test_reset();
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4)       line = J;
         else if (r < 8)  line = K;
         else if (r == 8) line = SE0;
         else             line = JJ;
         apply("random", line, $urandom_range(1, 4));
      end
   endtask

   task automatic test_back_to_back();
      test_reset();
      apply("b2b_j", J, 9);
      apply("b2b_k", K, 9);
      apply("b2b_se0", SE0, 3);
      apply("b2b_k_after", K, 3);
   endtask

   initial begin
      n_rst        = 1'b0;
      shift_enable = 1'b0;
      d_plus       = 1'b1;
      d_minus      = 1'b0;
      model_reset();
      test_reset();
      test_idle_j();
      test_nrzi();
      test_stuff_ok();
      test_stuff_err();
      test_eop();
      test_se0_in_stuff();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
